// File: rtl/multiword_adder.sv
// Sequential multi-word adder: adds two W = N*K bit operands one N-bit slice per
// cycle through a single carry-lookahead slice adder, then holds the result until taken.

module cla_adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co
);
    logic [N-1:0] g_s;
    logic [N-1:0] p_s;
    logic [N:0]   c_s;
    logic         term_s;
    logic         prop_s;

    assign g_s = a & b;
    assign p_s = a ^ b;

    // Each carry is a flat sum of generate terms gated by the propagate run below them
    always_comb begin
        c_s    = {(N+1){1'b0}};
        term_s = 1'b0;
        prop_s = 1'b1;
        c_s[0] = ci;
        for (int j = 0; j < N; j++) begin
            term_s = 1'b0;
            prop_s = 1'b1;
            for (int k = j; k >= 0; k--) begin
                term_s = term_s | (prop_s & g_s[k]);
                prop_s = prop_s & p_s[k];
            end
            c_s[j+1] = term_s | (prop_s & ci);
        end
    end

    assign s  = p_s ^ c_s[N-1:0];
    assign co = c_s[N];
endmodule

module multiword_adder #(
    parameter int N = 8,
    parameter int K = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*K-1:0] a,
    input  logic [N*K-1:0] b,
    input  logic           c_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*K-1:0] s,
    output logic           c_out,
    output logic           busy
);
    localparam int W  = N * K;
    localparam int IW = (K > 1) ? $clog2(K) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(K - 1);
    localparam logic [31:0]   SLICE_W  = 32'(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_nx_s;
    logic [W-1:0]  a_r;
    logic [W-1:0]  b_r;
    logic [W-1:0]  s_r;
    logic          carry_r;
    logic          c_out_r;
    logic [IW-1:0] idx_r;
    logic          out_valid_r;
    logic          busy_r;

    logic          accept_s;
    logic          last_s;
    logic [31:0]   off_s;
    logic [W-1:0]  a_sh_s;
    logic [W-1:0]  b_sh_s;
    logic [N-1:0]  slice_sum_s;
    logic          slice_co_s;
    logic [W-1:0]  slice_mask_s;
    logic [W-1:0]  slice_ins_s;

    // in_ready is gated by rst_n so it drops the moment reset asserts
    assign in_ready  = rst_n && (state_r == IDLE);
    assign accept_s  = in_valid && in_ready;
    assign last_s    = (idx_r == LAST_IDX);
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign s         = s_r;
    assign c_out     = c_out_r;

    assign off_s        = 32'(idx_r) * SLICE_W;
    assign a_sh_s       = a_r >> off_s;
    assign b_sh_s       = b_r >> off_s;
    assign slice_mask_s = W'({N{1'b1}}) << off_s;
    assign slice_ins_s  = W'(slice_sum_s) << off_s;

    cla_adder #(.N(N)) u_slice_add (
        .a  (a_sh_s[N-1:0]),
        .b  (b_sh_s[N-1:0]),
        .ci (carry_r),
        .s  (slice_sum_s),
        .co (slice_co_s)
    );

    // Control state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode; out_ready is only looked at in DONE, in_valid only in IDLE
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_nx_s = RUN;
                else          state_nx_s = IDLE;
            end
            RUN: begin
                if (last_s) state_nx_s = DONE;
                else        state_nx_s = RUN;
            end
            DONE: begin
                if (out_ready) state_nx_s = IDLE;
                else           state_nx_s = DONE;
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // Operand latch, per-slice sum/carry update and registered status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r         <= {W{1'b0}};
            b_r         <= {W{1'b0}};
            s_r         <= {W{1'b0}};
            carry_r     <= 1'b0;
            c_out_r     <= 1'b0;
            idx_r       <= {IW{1'b0}};
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        a_r     <= a;
                        b_r     <= b;
                        carry_r <= c_in;
                        idx_r   <= {IW{1'b0}};
                    end
                end
                RUN: begin
                    s_r     <= (s_r & ~slice_mask_s) | slice_ins_s;
                    carry_r <= slice_co_s;
                    if (last_s) begin
                        c_out_r <= slice_co_s;
                        idx_r   <= {IW{1'b0}};
                    end else begin
                        idx_r   <= idx_r + IW'(1);
                    end
                end
                DONE: begin
                    carry_r <= carry_r;
                end
                default: begin
                    idx_r <= {IW{1'b0}};
                end
            endcase
            out_valid_r <= (state_nx_s == DONE);
            busy_r      <= (state_nx_s != IDLE);
        end
    end
endmodule

// File: tb/tb_multiword_adder.sv
// Directed and randomised checks of multiword_adder (N=8, K=4) against a
// W+1-bit reference sum held in a scoreboard queue.

module tb_multiword_adder;
    localparam int N = 8;
    localparam int K = 4;
    localparam int W = N * K;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         c_in = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] s;
    logic         c_out;
    logic         busy;

    int           errors = 0;
    int           checks = 0;
    logic [W:0]   sb[$];
    logic [W:0]   last_exp = '0;

    multiword_adder #(.N(N), .K(K)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .c_out     (c_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_valid"}, 33'(out_valid), 33'd0);
        chk({tag, "_busy"},  33'(busy),      33'd0);
        chk({tag, "_s"},     33'(s),         33'd0);
        chk({tag, "_cout"},  33'(c_out),     33'd0);
        chk({tag, "_ready"}, 33'(in_ready),  33'd0);
    endtask

    // Present a request and wait for acceptance; the reference sum is queued on accept.
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic tc);
        int n;
        n = 0;
        a = ta;
        b = tbv;
        c_in = tc;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) begin
            chk("accept_timeout", 33'd0, 33'd1);
        end else begin
            @(posedge clk);
            #1;
            sb.push_back({1'b0, ta} + {1'b0, tbv} + 33'(tc));
        end
        in_valid = 1'b0;
    endtask

    // Count edges until out_valid, optionally pulsing in_valid/out_ready, then score the result.
    task automatic wait_result(input bit noisy);
        int lat;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            chk("run_ready", 33'(in_ready), 33'd0);
            chk("run_busy",  33'(busy),     33'd1);
            if (noisy) begin
                in_valid  = 1'($urandom_range(0, 1));
                out_ready = 1'($urandom_range(0, 1));
                a         = $urandom;
                b         = $urandom;
                c_in      = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("latency", 33'(lat), 33'(K));
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 33'd0, 33'd1);
            end else begin
                last_exp = sb.pop_front();
                chk("sum", {c_out, s}, last_exp);
            end
        end
    endtask

    // Keep out_ready low for n cycles while poking in_valid; the result must not move.
    task automatic hold(input int n);
        for (int i = 0; i < n; i++) begin
            out_ready = 1'b0;
            in_valid  = ~in_valid;
            a         = $urandom;
            b         = $urandom;
            @(posedge clk);
            #1;
            chk("hold_sum",   {c_out, s},       last_exp);
            chk("hold_valid", 33'(out_valid),   33'd1);
            chk("hold_ready", 33'(in_ready),    33'd0);
        end
        in_valid = 1'b0;
    endtask

    task automatic take();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("take_valid", 33'(out_valid), 33'd0);
        chk("take_busy",  33'(busy),      33'd0);
        chk("take_ready", 33'(in_ready),  33'd1);
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        // Power-on reset
        #12;
        chk_zero_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("por_rel_ready", 33'(in_ready), 33'd1);
        chk("por_rel_busy",  33'(busy),     33'd0);

        // Single slice carry into slice 1
        send(32'h0000_00FF, 32'h0000_0001, 1'b0);
        wait_result(1'b0);
        chk("ff_plus_1", {c_out, s}, 33'h0_0000_0100);

        // Mid-cycle reset while the result is being held
        #3;
        rst_n = 1'b0;
        #1;
        chk_zero_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_rel_ready", 33'(in_ready), 33'd1);
        chk("rst_rel_busy",  33'(busy),     33'd0);

        // Carry ripples through every slice
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        wait_result(1'b0);
        chk("full_ripple", {c_out, s}, 33'h1_0000_0000);
        take();

        // Overflow with carry-in
        send(32'h8000_0000, 32'h8000_0000, 1'b1);
        wait_result(1'b0);
        chk("ovf_cin", {c_out, s}, 33'h1_0000_0001);
        take();

        // Backpressure with in_valid pulsing
        send(32'h0F0F_0F0F, 32'hF0F0_F0F1, 1'b0);
        wait_result(1'b0);
        hold(5);
        take();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("no_second_valid", 33'(out_valid), 33'd0);
            chk("no_second_busy",  33'(busy),      33'd0);
        end

        // Reset while slice 2 is being added
        send(32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_valid", 33'(out_valid), 33'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 2 * K + 2; i++) begin
            @(posedge clk);
            #1;
            chk("aborted_never_valid", 33'(out_valid), 33'd0);
        end
        send(32'h1234_5678, 32'h1111_1111, 1'b0);
        wait_result(1'b0);
        chk("after_abort", {c_out, s}, 33'h0_2345_6789);
        take();

        // Random operations with random gaps and stalls
        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) rb = ~ra;
            send(ra, rb, 1'($urandom_range(0, 1)));
            wait_result(1'b1);
            hold($urandom_range(0, 3));
            take();
        end
        chk("sb_drained", 33'(sb.size()), 33'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
